// File: rtl/prm_scan_pkg.sv
// rtl/prm_scan_pkg.sv - shared defaults and types for the PRM edge scanner
package prm_scan_pkg;
    localparam int QW_DEF     = 15;
    localparam int WORD_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} scan_state_t;
    typedef logic [14:0] query_t;
endpackage

// File: rtl/prm_scan_pack.sv
// rtl/prm_scan_pack.sv - result accumulator, output word register and valid/ready handshake
module prm_scan_pack
    import prm_scan_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          bit_vld,
    input  logic                          bit_val,
    input  logic                          last_bit,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [$clog2(WORD_W+1)-1:0]   out_nbits,
    output logic [$clog2(WORD_W+1)-1:0]   acc_cnt,
    output logic                          last_xfer
);
    localparam int NB_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_acc;
    logic [NB_W-1:0]   r_cnt;
    logic              r_pend;
    logic              r_pend_last;
    logic [WORD_W-1:0] r_out_data;
    logic [NB_W-1:0]   r_out_nbits;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_out_free;
    logic [WORD_W-1:0] w_base_acc;
    logic [NB_W-1:0]   w_base_cnt;
    logic [WORD_W-1:0] w_mrg_acc;
    logic [NB_W-1:0]   w_mrg_cnt;
    logic              w_mrg_done;

    assign w_out_free = !r_out_valid || out_ready;

    // A pending complete word leaves this cycle only when the output register frees up,
    // so the incoming bit starts a fresh accumulator in that case.
    always_comb begin
        w_base_acc = r_pend ? '0 : r_acc;
        w_base_cnt = r_pend ? '0 : r_cnt;
        w_mrg_acc  = w_base_acc;
        w_mrg_cnt  = w_base_cnt;
        if (bit_vld) begin
            w_mrg_acc = w_base_acc | (WORD_W'(bit_val) << w_base_cnt);
            w_mrg_cnt = w_base_cnt + 1'b1;
        end
        w_mrg_done = bit_vld && ((w_mrg_cnt == NB_W'(WORD_W)) || last_bit);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_out_data  <= '0;
            r_out_nbits <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (r_pend && w_out_free) begin
            r_out_data  <= r_acc;
            r_out_nbits <= r_cnt;
            r_out_last  <= r_pend_last;
            r_out_valid <= 1'b1;
            r_acc       <= w_mrg_acc;
            r_cnt       <= w_mrg_cnt;
            r_pend      <= w_mrg_done;
            r_pend_last <= bit_vld && last_bit;
        end else if (!r_pend && w_mrg_done && w_out_free) begin
            r_out_data  <= w_mrg_acc;
            r_out_nbits <= w_mrg_cnt;
            r_out_last  <= last_bit;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (out_ready)
                r_out_valid <= 1'b0;
            if (!r_pend) begin
                r_acc       <= w_mrg_acc;
                r_cnt       <= w_mrg_cnt;
                r_pend      <= w_mrg_done;
                r_pend_last <= bit_vld && last_bit;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_nbits = r_out_nbits;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign acc_cnt   = r_cnt;
    assign last_xfer = r_out_valid && out_ready && r_out_last;
endmodule

// File: rtl/prm_edge_scan.sv
// rtl/prm_edge_scan.sv - sweeps query codes into a PRM checker and streams packed results; PRM_EDGE_SCAN_HITCNT_EN adds hit statistics
module prm_edge_scan
    import prm_scan_pkg::*;
#(
    parameter int QW      = QW_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int CHK_LAT = 1
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          start,
    input  logic [QW-1:0]                 start_idx,
    input  logic [QW-1:0]                 end_idx,
    output logic                          busy,
    output logic                          done,
    output logic [QW-1:0]                 chk_query,
    input  logic                          chk_mask,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(WORD_W+1)-1:0]   out_nbits
`ifdef PRM_EDGE_SCAN_HITCNT_EN
    ,
    output logic [QW:0]                   hit_cnt,
    output logic [QW-1:0]                 first_hit,
    output logic                          first_hit_vld
`endif
);
    localparam int NB_W = $clog2(WORD_W + 1);
    localparam int CW   = $clog2(WORD_W + CHK_LAT + 2);

    scan_state_t       r_state;
    logic [QW:0]       r_cur;
    logic [QW-1:0]     r_hi;
    logic [QW-1:0]     r_query;
    logic              r_busy;
    logic              r_done;
    logic [CHK_LAT:0]  r_dly_vld;
    logic [CHK_LAT:0]  r_dly_last;

    logic              w_swap;
    logic [QW-1:0]     w_lo;
    logic [QW-1:0]     w_hi;
    logic [NB_W-1:0]   w_acc_cnt;
    logic [CW-1:0]     w_sum;
    logic              w_stall;
    logic              w_issue;
    logic              w_last_xfer;
    logic              w_bit_vld;

    assign w_swap    = end_idx < start_idx;
    assign w_lo      = w_swap ? end_idx : start_idx;
    assign w_hi      = w_swap ? start_idx : end_idx;
    assign w_bit_vld = r_dly_vld[CHK_LAT];

    // Stage 0 is valid while its query sits on chk_query; the result is sampled at stage CHK_LAT.
    always_comb begin
        w_sum = CW'(w_acc_cnt);
        for (int i = 0; i <= CHK_LAT; i++)
            w_sum = w_sum + CW'(r_dly_vld[i]);
    end

    assign w_stall = out_valid && !out_ready && (w_sum >= CW'(WORD_W));
    assign w_issue = (r_state == ISSUE) && !w_stall;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= IDLE;
            r_cur      <= '0;
            r_hi       <= '0;
            r_query    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dly_vld  <= '0;
            r_dly_last <= '0;
        end else begin
            r_done        <= 1'b0;
            r_dly_vld[0]  <= w_issue;
            r_dly_last[0] <= w_issue && (r_cur == {1'b0, r_hi});
            for (int i = 1; i <= CHK_LAT; i++) begin
                r_dly_vld[i]  <= r_dly_vld[i-1];
                r_dly_last[i] <= r_dly_last[i-1];
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur   <= {1'b0, w_lo};
                        r_hi    <= w_hi;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_query <= r_cur[QW-1:0];
                        r_cur   <= r_cur + 1'b1;
                        if (r_cur == {1'b0, r_hi})
                            r_state <= DRAIN;
                    end
                end
                DRAIN, FLUSH: begin
                    if (w_last_xfer) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_state == DRAIN && r_dly_vld == '0) begin
                        r_state <= FLUSH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    prm_scan_pack #(
        .WORD_W (WORD_W)
    ) u_pack (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .bit_vld   (w_bit_vld),
        .bit_val   (chk_mask),
        .last_bit  (r_dly_last[CHK_LAT]),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_nbits (out_nbits),
        .acc_cnt   (w_acc_cnt),
        .last_xfer (w_last_xfer)
    );

`ifdef PRM_EDGE_SCAN_HITCNT_EN
    logic [QW:0]   r_hit_cnt;
    logic [QW-1:0] r_first_hit;
    logic          r_first_vld;
    logic [QW-1:0] r_smp_idx;

    // Results arrive in ascending query order, so the first hit is the lowest code.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_hit_cnt   <= '0;
            r_first_hit <= '0;
            r_first_vld <= 1'b0;
            r_smp_idx   <= '0;
        end else if (r_state == IDLE && start) begin
            r_hit_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_smp_idx   <= w_lo;
        end else if (w_bit_vld) begin
            r_smp_idx <= r_smp_idx + 1'b1;
            if (chk_mask) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_hit <= r_smp_idx;
                end
            end
        end
    end

    assign hit_cnt       = r_hit_cnt;
    assign first_hit     = r_first_hit;
    assign first_hit_vld = r_first_vld;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign chk_query = r_query;
endmodule

// File: doc/prm_edge_scan.md
Name: prm_edge_scan

Overview:
- Sequencing initiator for the combinational PRM obstacle-logic checkers (15-bit query in A..O, 1-bit edge_mask out).
- Sweeps a programmed range of 15-bit query codes, drives them to an external checker, and samples each result after a fixed latency.
- Packs results LSB-first into words and streams them on a valid/ready interface to the roadmap edge-table writer.

Parameters:
- QW, 15, query width; bit0 maps to checker input A, bit14 to O.
- WORD_W, 32, packed output word width; range 2..64.
- CHK_LAT, 1, cycles from chk_query change to a valid chk_mask; range 0..4. 0 means same-cycle combinational.

Ports:
- CLK  in  1  clock.
- RST_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- start_idx  in  QW  first query code; sampled on accepted start.
- end_idx  in  QW  last query code, inclusive; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the last word is accepted.
- chk_query  out  QW  query code driven to the checker.
- chk_mask  in  1  checker result.
- out_data  out  WORD_W  packed results; bit k = result of the k-th query in this word.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accept.
- out_last  out  1  qualifies the final word of a sweep.
- out_nbits  out  $clog2(WORD_W+1)  number of valid bits in out_data.

Behaviour:
- Reset values: busy=0, done=0, chk_query=0, out_data=0, out_valid=0, out_last=0, out_nbits=0. FSM enters IDLE, all counters cleared.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - On start, latch the range.
  - If end_idx < start_idx: swap them and sweep ascending.
  - Load cur=lo, go to ISSUE.
- ISSUE:
  - Each non-stalled cycle: chk_query<=cur, push a valid bit into a CHK_LAT-deep delay line, cur<=cur+1.
  - After issuing cur==hi, go to DRAIN.
  - Range hi-lo+1 spans 1..32768 queries. cur needs QW+1 bits so hi=0x7FFF does not wrap.
- DRAIN: wait until the delay line is empty, then go to FLUSH.
- FLUSH:
  - If the accumulator holds bits, present them with out_last=1.
  - If the accumulator is empty and the final word was already emitted, assert done and go to IDLE.
- Sampling: when the delay-line tail is valid, chk_mask is shifted into accumulator bit position acc_cnt.
- Word formation:
  - When acc_cnt reaches WORD_W, the word moves to the output register: out_valid=1, out_nbits=WORD_W.
  - out_last=1 only if it carries the final query.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_data, out_nbits and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid drops the cycle after a transfer unless a new word loads in that same cycle.
- Stall rule:
  - Issue stalls when out_valid=1, out_ready=0, and acc_cnt + inflight >= WORD_W.
  - This guarantees no result is lost. chk_query holds its value during a stall.
- Simultaneous events:
  - A transfer and a new word completion in the same cycle load the new word back-to-back with out_valid held at 1.
  - start while busy is ignored.
- Exact multiple: if the final word fills exactly WORD_W bits, it carries out_last=1 and FLUSH emits nothing further.
- Reset mid-sweep aborts immediately. Partial words are discarded with no out_last and no done.
- Throughput: one query per cycle when unstalled.
- Latency: first out_valid appears WORD_W+CHK_LAT+1 cycles after start, when the range is at least WORD_W.

Optional Feature:
- Macro: PRM_EDGE_SCAN_HITCNT_EN.
- With the macro defined:
  - Adds output hit_cnt (QW+1 bits), a count of chk_mask=1 results in the current sweep.
  - Cleared on accepted start, holds its value after done.
  - Adds output first_hit (QW bits) plus first_hit_vld, giving the lowest query code whose result was 1.
- Without the macro: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package prm_scan_pkg holds:
  - QW_DEF=15, WORD_W_DEF=32.
  - scan_state_t enum {IDLE, ISSUE, DRAIN, FLUSH}.
  - query_t typedef logic [14:0].
- One sub-module, prm_scan_pack: accumulator, output register and handshake, with inputs bit_vld/bit_val/last_bit.

Test Plan:
- start_idx=0, end_idx=31, WORD_W=32, checker tied to chk_query[0], out_ready=1 -> one word 0xAAAAAAAA, out_nbits=32, out_last=1, done one cycle later.
- start_idx=5, end_idx=5, checker returns 1 -> one word 0x00000001, out_nbits=1, out_last=1.
- start_idx=100, end_idx=40 -> sweeps 40..100 ascending: words of 32 and 29 bits, the second with out_last.
- Range 0..95, out_ready held low 50 cycles after the first word -> issue stalls, data is stable, all 3 words are delivered in order with none lost.
- start_idx=0x7FE0, end_idx=0x7FFF, CHK_LAT=3 -> 32 results, no wrap, exactly one word with out_last.
- Assert RST_n low mid-sweep, then restart 0..31 -> outputs reach reset values asynchronously, the second sweep completes correctly, and no stale bits appear.
